// File: rtl/seg7_decoder_if.sv
// ---------------------------------------------------------------------------
// seg7_decoder_if
// Bundles the segment-sample input stream and the decoded-digit output
// handshake of seg7_decoder.
//   seg_in      [6:0] active-low segment pattern {g,f,e,d,c,b,a}
//   seg_valid         qualifies seg_in this cycle
//   dout        [3:0] decoded hex digit
//   dout_valid        dout holds an unconsumed digit
//   dout_ready        consumer acceptance
//   err               one-cycle pulse after an illegal pattern locked
//   err_cnt     [7:0] saturating count of illegal locked patterns
//   overrun           sticky flag: a decoded digit was dropped
// master: the environment side (drives samples and ready)
// slave : the decoder side
// ---------------------------------------------------------------------------
interface seg7_decoder_if;
   logic [6:0] seg_in;
   logic       seg_valid;
   logic [3:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       err;
   logic [7:0] err_cnt;
   logic       overrun;

   modport master (
      output seg_in, seg_valid, dout_ready,
      input  dout, dout_valid, err, err_cnt, overrun
   );

   modport slave (
      input  seg_in, seg_valid, dout_ready,
      output dout, dout_valid, err, err_cnt, overrun
   );
endinterface

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Debounces an active-low 7-segment pattern: a pattern must be seen valid and
// unchanged for STABLE_CYCLES consecutive edges before it is captured once.
// Legal captures are decoded to a hex digit and offered on a valid/ready
// output; illegal captures pulse err and bump a saturating error counter.
// A legal digit arriving while an unaccepted digit is pending is dropped and
// recorded in the sticky overrun flag.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_decoder_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module seg7_decoder #(
   parameter int STABLE_CYCLES = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seg7_decoder_if.slave        bus
);

   localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Returns {legal, digit}; every pattern outside the 16-entry table is illegal.
   function automatic logic [4:0] seg_decode(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'b1000000: res = 5'h10;
         7'b1111001: res = 5'h11;
         7'b0100100: res = 5'h12;
         7'b0110000: res = 5'h13;
         7'b0011001: res = 5'h14;
         7'b0010010: res = 5'h15;
         7'b0000010: res = 5'h16;
         7'b1111000: res = 5'h17;
         7'b0000000: res = 5'h18;
         7'b0010000: res = 5'h19;
         7'b0001000: res = 5'h1A;
         7'b0000011: res = 5'h1B;
         7'b1000110: res = 5'h1C;
         7'b0100001: res = 5'h1D;
         7'b0000110: res = 5'h1E;
         7'b0001110: res = 5'h1F;
         default:    res = 5'h00;
      endcase
      return res;
   endfunction

   state_t     state_r,      state_nxt_s;
   logic [3:0] cnt_r,        cnt_nxt_s;
   logic [6:0] sample_r,     sample_nxt_s;
   logic       capture_s;
   logic [3:0] cnt_inc_s;

   logic [3:0] dout_r,       dout_nxt_s;
   logic       dout_valid_r, dout_valid_nxt_s;
   logic       err_r,        err_nxt_s;
   logic [7:0] err_cnt_r,    err_cnt_nxt_s;
   logic       overrun_r,    overrun_nxt_s;
   logic [4:0] dec_s;

   assign cnt_inc_s = cnt_r + 4'd1;
   assign dec_s     = seg_decode(bus.seg_in);

   // Next-state logic of the debounce tracker; capture_s marks the lock edge.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      sample_nxt_s = sample_r;
      capture_s    = 1'b0;
      case (state_r)
         IDLE, TRACK, LOCKED: begin
            if (!bus.seg_valid) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 4'd0;
            end else if ((state_r == IDLE) || (bus.seg_in != sample_r)) begin
               // A fresh pattern counts as its own first match.
               sample_nxt_s = bus.seg_in;
               cnt_nxt_s    = 4'd1;
               if (STABLE_C == 4'd1) begin
                  capture_s   = 1'b1;
                  state_nxt_s = LOCKED;
               end else begin
                  state_nxt_s = TRACK;
               end
            end else if (state_r == TRACK) begin
               cnt_nxt_s = cnt_inc_s;
               if (cnt_inc_s == STABLE_C) begin
                  capture_s   = 1'b1;
                  state_nxt_s = LOCKED;
               end else begin
                  state_nxt_s = TRACK;
               end
            end else begin
               // LOCKED on the same pattern: hold without recapturing.
               state_nxt_s = LOCKED;
            end
         end
         default: begin
            state_nxt_s  = IDLE;
            cnt_nxt_s    = 4'd0;
            sample_nxt_s = 7'b1111111;
         end
      endcase
   end

   // Output-side next values: digit handoff, overrun, error pulse and counter.
   always_comb begin
      dout_nxt_s       = dout_r;
      dout_valid_nxt_s = dout_valid_r;
      overrun_nxt_s    = overrun_r;
      err_nxt_s        = capture_s & ~dec_s[4];
      err_cnt_nxt_s    = err_cnt_r;
      if (capture_s && dec_s[4]) begin
         if (!dout_valid_r || bus.dout_ready) begin
            dout_nxt_s       = dec_s[3:0];
            dout_valid_nxt_s = 1'b1;
         end else begin
            overrun_nxt_s = 1'b1;
         end
      end else if (dout_valid_r && bus.dout_ready) begin
         dout_valid_nxt_s = 1'b0;
      end else begin
         dout_valid_nxt_s = dout_valid_r;
      end
      if (capture_s && !dec_s[4] && (err_cnt_r != 8'hFF)) begin
         err_cnt_nxt_s = err_cnt_r + 8'd1;
      end else begin
         err_cnt_nxt_s = err_cnt_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         sample_r     <= 7'b1111111;
         dout_r       <= 4'd0;
         dout_valid_r <= 1'b0;
         err_r        <= 1'b0;
         err_cnt_r    <= 8'd0;
         overrun_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         sample_r     <= sample_nxt_s;
         dout_r       <= dout_nxt_s;
         dout_valid_r <= dout_valid_nxt_s;
         err_r        <= err_nxt_s;
         err_cnt_r    <= err_cnt_nxt_s;
         overrun_r    <= overrun_nxt_s;
      end
   end

   assign bus.dout       = dout_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.err        = err_r;
   assign bus.err_cnt    = err_cnt_r;
   assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_seg7_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_decoder
// Directed scenarios followed by randomized traffic, each cycle compared
// against a run-length reference model of the decoder.
// ---------------------------------------------------------------------------
module tb_seg7_decoder;

   localparam int STABLE = 3;

   logic clk;
   logic rst_n;

   seg7_decoder_if bus ();

   seg7_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Legal patterns indexed by the digit they encode.
   logic [6:0] legal_pat [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state: length of the current run of identical valid samples.
   int         m_run;
   logic [6:0] m_pat;
   logic [3:0] m_dout;
   logic       m_valid;
   logic       m_err;
   int         m_errcnt;
   logic       m_ovr;

   task automatic model_reset();
      m_run = 0; m_pat = 7'b1111111; m_dout = 4'd0; m_valid = 1'b0;
      m_err = 1'b0; m_errcnt = 0; m_ovr = 1'b0;
   endtask

   task automatic model_step(input bit v, input logic [6:0] p, input bit r);
      bit cap, legal, accept;
      logic [3:0] dig;
      legal = 1'b0; dig = 4'd0;
      for (int i = 0; i < 16; i++)
         if (legal_pat[i] == p) begin legal = 1'b1; dig = 4'(i); end
      if (!v) m_run = 0;
      else if (m_run > 0 && p == m_pat) m_run++;
      else begin m_pat = p; m_run = 1; end
      cap    = v && (m_run == STABLE);
      accept = m_valid && r;
      m_err  = cap && !legal;
      if (cap && !legal && m_errcnt < 255) m_errcnt++;
      if (cap && legal) begin
         if (!m_valid || r) begin m_dout = dig; m_valid = 1'b1; end
         else m_ovr = 1'b1;
      end else if (accept) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("dout",       {4'd0, bus.dout},       {4'd0, m_dout});
      chk("dout_valid", {7'd0, bus.dout_valid}, {7'd0, m_valid});
      chk("err",        {7'd0, bus.err},        {7'd0, m_err});
      chk("err_cnt",    bus.err_cnt,            8'(m_errcnt));
      chk("overrun",    {7'd0, bus.overrun},    {7'd0, m_ovr});
   endtask

   // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
   task automatic cyc(input bit v, input logic [6:0] p, input bit r);
      bus.seg_valid  = v;
      bus.seg_in     = p;
      bus.dout_ready = r;
      model_step(v, p, r);
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Asserts reset between edges; outputs must clear with no clock edge.
   task automatic async_reset();
      rst_n = 1'b0;
      bus.seg_valid = 1'b0;
      #2;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [6:0] cur;
   bit         rv;

   initial begin
      rst_n = 1'b0;
      bus.seg_in = 7'b1111111;
      bus.seg_valid = 1'b0;
      bus.dout_ready = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Digit 4 held three edges, accepted next cycle, no second valid.
      cyc(1'b1, 7'b0011001, 1'b1);
      cyc(1'b1, 7'b0011001, 1'b1);
      chk("d4_not_early", {7'd0, bus.dout_valid}, 8'd0);
      cyc(1'b1, 7'b0011001, 1'b1);
      chk("d4_dout", {4'd0, bus.dout}, 8'd4);
      chk("d4_valid", {7'd0, bus.dout_valid}, 8'd1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 7'b0011001, 1'b1);
      chk("d4_once", {7'd0, bus.dout_valid}, 8'd0);

      // Interrupted run of 0 then stable 1; then a run cut by seg_valid dropping.
      cyc(1'b0, 7'b1111111, 1'b0);
      cyc(1'b1, 7'b1000000, 1'b0);
      cyc(1'b1, 7'b1000000, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 7'b1111001, 1'b0);
      chk("d1_dout", {4'd0, bus.dout}, 8'd1);
      cyc(1'b0, 7'b1111111, 1'b1);
      cyc(1'b1, 7'b1000000, 1'b1);
      cyc(1'b1, 7'b1000000, 1'b1);
      cyc(1'b0, 7'b1000000, 1'b1);
      cyc(1'b1, 7'b1000000, 1'b1);
      chk("drop_no_out", {7'd0, bus.dout_valid}, 8'd0);

      // Illegal pattern locks: err pulse, counter, saturation.
      cyc(1'b0, 7'b1111111, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 7'b1111111, 1'b1);
      chk("ill_err", {7'd0, bus.err}, 8'd1);
      chk("ill_cnt", bus.err_cnt, 8'd1);
      cyc(1'b1, 7'b1111111, 1'b1);
      chk("ill_err_1cyc", {7'd0, bus.err}, 8'd0);
      for (int n = 0; n < 299; n++) begin
         cyc(1'b0, 7'b1111111, 1'b1);
         for (int i = 0; i < 3; i++) cyc(1'b1, 7'b1111111, 1'b1);
      end
      chk("ill_sat", bus.err_cnt, 8'd255);

      // Capture of F coinciding with acceptance of a pending A.
      async_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 7'b0001000, 1'b0);
      cyc(1'b1, 7'b0001110, 1'b0);
      cyc(1'b1, 7'b0001110, 1'b0);
      cyc(1'b1, 7'b0001110, 1'b1);
      chk("f_dout", {4'd0, bus.dout}, 8'hF);
      chk("f_valid", {7'd0, bus.dout_valid}, 8'd1);
      chk("f_ovr", {7'd0, bus.overrun}, 8'd0);
      cyc(1'b0, 7'b1111111, 1'b1);

      // Overrun: 2 pending, 8 dropped; then acceptance clears valid.
      for (int i = 0; i < 3; i++) cyc(1'b1, 7'b0100100, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 7'b0000000, 1'b0);
      chk("ovr_dout", {4'd0, bus.dout}, 8'd2);
      chk("ovr_flag", {7'd0, bus.overrun}, 8'd1);
      cyc(1'b0, 7'b1111111, 1'b1);
      chk("ovr_clear_valid", {7'd0, bus.dout_valid}, 8'd0);
      chk("ovr_sticky", {7'd0, bus.overrun}, 8'd1);

      // Reset with a digit pending and mid-track; relock needs 3 edges again.
      for (int i = 0; i < 3; i++) cyc(1'b1, 7'b0110000, 1'b0);
      cyc(1'b1, 7'b0010010, 1'b0);
      cyc(1'b1, 7'b0010010, 1'b0);
      async_reset();
      cyc(1'b1, 7'b0010010, 1'b0);
      cyc(1'b1, 7'b0010010, 1'b0);
      chk("rst_relock_wait", {7'd0, bus.dout_valid}, 8'd0);
      cyc(1'b1, 7'b0010010, 1'b0);
      chk("rst_relock_dout", {4'd0, bus.dout}, 8'd5);

      // Randomized traffic with sticky patterns so locks happen often.
      async_reset();
      cur = legal_pat[0];
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 5))
               0:       cur = 7'($urandom);
               1:       cur = 7'b1111111;
               default: cur = legal_pat[$urandom_range(0, 15)];
            endcase
         end
         rv = ($urandom_range(0, 2) != 0);
         cyc(($urandom_range(0, 9) != 0), cur, rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 3, giving the number of consecutive identical valid samples required before decode; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all flops update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port seg_in, input, 7, active-low segment pattern {g,f,e,d,c,b,a}.
REQ-005 SHALL have port seg_valid, input, 1, qualifying seg_in this cycle.
REQ-006 SHALL have port dout, output, 4, the decoded hex digit.
REQ-007 SHALL have port dout_valid, output, 1, indicating dout holds an unconsumed digit.
REQ-008 SHALL have port dout_ready, input, 1, consumer acceptance.
REQ-009 SHALL have port err, output, 1, a one-cycle pulse on an illegal locked pattern.
REQ-010 SHALL have port err_cnt, output, 8, the count of illegal patterns.
REQ-011 SHALL have port overrun, output, 1, a sticky flag set when a decoded digit was dropped.

Function
REQ-012 SHALL decode only these 16 legal patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-013 SHALL decode only these 16 legal patterns (continued): 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110; every other pattern is illegal.
REQ-014 SHALL implement states IDLE, TRACK and LOCKED, with 4-bit match counter cnt and 7-bit held sample.
REQ-015 SHALL move from IDLE with seg_valid=1 to TRACK, with sample=seg_in and cnt=1; seg_valid=0 keeps it in IDLE.
REQ-016 SHALL, in TRACK with seg_valid=1 and seg_in==sample, increment cnt; on the edge where cnt reaches STABLE_CYCLES, capture and go to LOCKED.
REQ-017 SHALL, in TRACK or LOCKED with seg_valid=1 and seg_in!=sample, go to TRACK with sample=seg_in and cnt=1.
REQ-018 SHALL go from any state to IDLE when seg_valid=0, with cnt cleared and no capture.
REQ-019 SHALL capture exactly once per lock; LOCKED holding the same pattern produces no further captures.
REQ-020 SHALL capture immediately on the first valid edge when STABLE_CYCLES=1, going straight to LOCKED.
REQ-021 SHALL, on capture of a legal pattern, register the digit into dout and set dout_valid on that same edge; latency is STABLE_CYCLES edges from the first sampled pattern.
REQ-022 SHALL, on capture of an illegal pattern, pulse err high for exactly the following cycle, increment err_cnt (saturating at 255), and leave dout/dout_valid unchanged.
REQ-023 SHALL clear dout_valid on the edge where dout_valid=1 and dout_ready=1, unless a legal capture occurs on that same edge.
REQ-024 SHALL, when a legal capture coincides with acceptance (dout_valid=1, dout_ready=1), load the new digit and keep dout_valid=1 with no overrun.
REQ-025 SHALL, on a legal capture while dout_valid=1 and dout_ready=0, drop the new digit, keep dout unchanged and set overrun=1.
REQ-026 SHALL keep dout stable while dout_valid=1 and not accepted.
REQ-027 SHALL make err_cnt wrap-free: at 255 it stays at 255.
REQ-028 SHALL make overrun sticky, cleared only by reset.

Reset
REQ-029 SHALL, on rst_n=0, immediately force: state IDLE, cnt=0, sample=7'b1111111, dout=0, dout_valid=0, err=0, err_cnt=0, overrun=0.
REQ-030 SHALL, on reset asserted mid-TRACK or with dout_valid=1, discard all pending state with no capture, err or valid emitted.
REQ-031 SHALL sample inputs first on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL verify that seg_in=0011001 with seg_valid held for 3 edges and dout_ready=1 gives dout=4 and dout_valid=1 for one cycle after the 3rd edge; holding the pattern gives no second valid.
REQ-033 SHALL verify that 1000000 for 2 edges, then 1111001 for 3 edges, gives only dout=1 with no digit 0, and that seg_valid dropping after 2 edges gives no output.
REQ-034 SHALL verify that seg_in=1111111 held for 3 edges gives err pulsing 1 cycle, err_cnt=1 and dout_valid=0; 300 illegal locks give err_cnt=255.
REQ-035 SHALL verify that with dout_ready=0, locking 2=0100100 then 8=0000000 gives dout=2 retained and overrun=1; then dout_ready=1 clears dout_valid.
REQ-036 SHALL verify that a capture of F=0001110 on the same edge as acceptance of a pending A gives dout=F, dout_valid=1 and overrun=0.
REQ-037 SHALL verify that asserting rst_n=0 mid-TRACK and with dout_valid=1 clears all outputs asynchronously, and that after release 3 stable edges are again required.
